// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: deals cards over a req/valid handshake, runs the
// player turn from button pulses, plays the dealer rule and settles the result.
module blackjack_round_ctrl #(
   parameter int DEALER_STAND = 17,
   parameter int MAX_CARDS    = 8,
   parameter int TARGET       = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       player_hit,
   input  logic       player_stand,
   output logic       card_req,
   input  logic       card_valid,
   input  logic [3:0] card_rank,
   output logic [7:0] player_total,
   output logic [7:0] dealer_total,
   output logic       player_soft,
   output logic       busy,
   output logic       done,
   output logic [1:0] result
);

   localparam int CNT_W = $clog2(MAX_CARDS + 1);

   typedef enum logic [3:0] {
      IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, CHECK_BJ,
      PLAYER_TURN, PLAYER_DRAW, DEALER_TURN, DEALER_DRAW, SETTLE, DONE
   } state_t;

   state_t           state, state_nxt;
   logic [7:0]       p_hard, d_hard;
   logic             p_ace, d_ace;
   logic [CNT_W-1:0] p_cnt, d_cnt;
   logic [7:0]       card_val, p_best, d_best;
   logic             rank_ok, take, p_take, d_take, start_ok, card_req_nxt;
   logic             p_bust, d_bust, p_bj, d_bj;
   logic [1:0]       settle_res;

   function automatic logic soft_total(input logic [7:0] hard, input logic ace);
      return ace && ((hard + 8'd10) <= 8'(TARGET));
   endfunction

   function automatic logic [7:0] best_total(input logic [7:0] hard, input logic ace);
      if (soft_total(hard, ace))
         return hard + 8'd10;
      return hard;
   endfunction

   function automatic logic is_draw(input state_t s);
      return (s == DEAL_P1) || (s == DEAL_D1) || (s == DEAL_P2) ||
             (s == DEAL_D2) || (s == PLAYER_DRAW) || (s == DEALER_DRAW);
   endfunction

   // Face cards count 10; out-of-range ranks are swallowed without advancing.
   always_comb begin
      rank_ok  = 1'b1;
      card_val = 8'd0;
      case (card_rank)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
         4'd6, 4'd7, 4'd8, 4'd9, 4'd10: card_val = {4'd0, card_rank};
         4'd11, 4'd12, 4'd13:            card_val = 8'd10;
         default:                        rank_ok  = 1'b0;
      endcase
   end

   assign take     = card_req && card_valid && rank_ok;
   assign p_take   = take && ((state == DEAL_P1) || (state == DEAL_P2) || (state == PLAYER_DRAW));
   assign d_take   = take && ((state == DEAL_D1) || (state == DEAL_D2) || (state == DEALER_DRAW));
   assign start_ok = start && ((state == IDLE) || (state == DONE));

   assign p_best = best_total(p_hard, p_ace);
   assign d_best = best_total(d_hard, d_ace);
   assign p_bust = p_hard > 8'(TARGET);
   assign d_bust = d_hard > 8'(TARGET);
   assign p_bj   = (p_cnt == CNT_W'(2)) && (p_best == 8'(TARGET));
   assign d_bj   = (d_cnt == CNT_W'(2)) && (d_best == 8'(TARGET));

   always_comb begin
      if (p_bust)              settle_res = 2'b10;
      else if (d_bust)         settle_res = 2'b01;
      else if (p_bj && d_bj)   settle_res = 2'b11;
      else if (p_bj)           settle_res = 2'b01;
      else if (d_bj)           settle_res = 2'b10;
      else if (p_best > d_best) settle_res = 2'b01;
      else if (p_best < d_best) settle_res = 2'b10;
      else                     settle_res = 2'b11;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE:  if (start) state_nxt = DEAL_P1;
         DEAL_P1:     if (take) state_nxt = DEAL_D1;
         DEAL_D1:     if (take) state_nxt = DEAL_P2;
         DEAL_P2:     if (take) state_nxt = DEAL_D2;
         DEAL_D2:     if (take) state_nxt = CHECK_BJ;
         CHECK_BJ:    state_nxt = ((p_best == 8'(TARGET)) || (d_best == 8'(TARGET))) ? SETTLE : PLAYER_TURN;
         PLAYER_TURN: begin
            if (player_stand || (p_cnt >= CNT_W'(MAX_CARDS))) state_nxt = DEALER_TURN;
            else if (player_hit)                               state_nxt = PLAYER_DRAW;
         end
         PLAYER_DRAW: if (take) state_nxt = ((p_hard + card_val) > 8'(TARGET)) ? SETTLE : PLAYER_TURN;
         DEALER_TURN: state_nxt = ((d_best < 8'(DEALER_STAND)) && (d_cnt < CNT_W'(MAX_CARDS))) ? DEALER_DRAW : SETTLE;
         DEALER_DRAW: if (take) state_nxt = DEALER_TURN;
         SETTLE:      state_nxt = DONE;
         default:     state_nxt = IDLE;
      endcase
   end

   // Request drops for one cycle after each accepted card, never after a discard.
   assign card_req_nxt = is_draw(state_nxt) && !take;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         card_req <= 1'b0;
         result   <= 2'b00;
         p_hard   <= 8'd0;
         d_hard   <= 8'd0;
         p_ace    <= 1'b0;
         d_ace    <= 1'b0;
         p_cnt    <= '0;
         d_cnt    <= '0;
      end else begin
         state    <= state_nxt;
         card_req <= card_req_nxt;
         if (start_ok) begin
            result <= 2'b00;
            p_hard <= 8'd0;
            d_hard <= 8'd0;
            p_ace  <= 1'b0;
            d_ace  <= 1'b0;
            p_cnt  <= '0;
            d_cnt  <= '0;
         end else begin
            if (state == SETTLE) result <= settle_res;
            if (p_take) begin
               p_hard <= p_hard + card_val;
               p_cnt  <= p_cnt + CNT_W'(1);
               if (card_val == 8'd1) p_ace <= 1'b1;
            end
            if (d_take) begin
               d_hard <= d_hard + card_val;
               d_cnt  <= d_cnt + CNT_W'(1);
               if (card_val == 8'd1) d_ace <= 1'b1;
            end
         end
      end
   end

   assign player_total = p_best;
   assign dealer_total = d_best;
   assign player_soft  = soft_total(p_hard, p_ace);
   assign busy         = (state != IDLE) && (state != DONE);
   assign done         = (state == DONE);

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed bench for blackjack_round_ctrl: a card-list model of both hands is
// compared against the DUT every cycle, plus literal end-of-round expectations.
module tb_blackjack_round_ctrl;

   logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
   logic       player_hit = 1'b0, player_stand = 1'b0, card_valid = 1'b0;
   logic [3:0] card_rank = 4'd0;
   logic       card_req, player_soft, busy, done;
   logic [7:0] player_total, dealer_total;
   logic [1:0] result;

   int n_cmp = 0, n_bad = 0;
   int p_q[$], d_q[$];
   bit chk_en = 1'b0;
   int acc_cnt = 0, req_cnt = 0;

   blackjack_round_ctrl #(.DEALER_STAND(17), .MAX_CARDS(8), .TARGET(21)) dut (
      .clk(clk), .rst(rst), .start(start), .player_hit(player_hit),
      .player_stand(player_stand), .card_req(card_req), .card_valid(card_valid),
      .card_rank(card_rank), .player_total(player_total), .dealer_total(dealer_total),
      .player_soft(player_soft), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   function automatic int cval(input int r);
      return (r >= 10) ? 10 : r;
   endfunction

   function automatic int hard_of(input int q[$]);
      int s = 0;
      foreach (q[i]) s += cval(q[i]);
      return s;
   endfunction

   function automatic bit soft_of(input int q[$]);
      bit ace = 1'b0;
      foreach (q[i]) if (q[i] == 1) ace = 1'b1;
      return ace && (hard_of(q) + 10 <= 21);
   endfunction

   function automatic int best_of(input int q[$]);
      return soft_of(q) ? hard_of(q) + 10 : hard_of(q);
   endfunction

   function automatic int model_result();
      bit pbj, dbj;
      int pb, db;
      pb  = best_of(p_q);
      db  = best_of(d_q);
      pbj = (p_q.size() == 2) && (pb == 21);
      dbj = (d_q.size() == 2) && (db == 21);
      if (hard_of(p_q) > 21) return 2;
      if (hard_of(d_q) > 21) return 1;
      if (pbj && dbj) return 3;
      if (pbj) return 1;
      if (dbj) return 2;
      if (pb > db) return 1;
      if (pb < db) return 2;
      return 3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && rst) begin
         chk("player_total", player_total, best_of(p_q));
         chk("dealer_total", dealer_total, best_of(d_q));
         chk("player_soft", player_soft, soft_of(p_q));
      end
   end

   always @(negedge clk) begin
      if (card_req && card_valid) acc_cnt++;
      if (card_req) req_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
      p_q.delete();
      d_q.delete();
   endtask

   task automatic give(input int rank, input bit to_p, input bit discard);
      int t = 0;
      while (!card_req && t < 20) begin
         step();
         t++;
      end
      if (!card_req) begin
         chk("card_req_wait", card_req, 1);
         return;
      end
      card_valid = 1'b1;
      card_rank  = 4'(rank);
      step();
      card_valid = 1'b0;
      if (discard) chk("req_after_discard", card_req, 1);
      else if (to_p) p_q.push_back(rank);
      else d_q.push_back(rank);
   endtask

   task automatic deal4(input int a, input int b, input int c, input int e);
      give(a, 1'b1, 1'b0);
      give(b, 1'b0, 1'b0);
      give(c, 1'b1, 1'b0);
      give(e, 1'b0, 1'b0);
   endtask

   task automatic pulse(input bit h, input bit s);
      player_hit   = h;
      player_stand = s;
      step();
      player_hit   = 1'b0;
      player_stand = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 100) begin
         step();
         cyc++;
      end
      chk("done_reached", done, 1);
   endtask

   task automatic check_end(input string tag, input int pt, input int dt, input int res);
      chk({tag, "_player"}, player_total, pt);
      chk({tag, "_dealer"}, dealer_total, dt);
      chk({tag, "_result"}, result, res);
      chk({tag, "_model_result"}, result, model_result());
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int cyc, a0, r0;
      // reset state
      step();
      step();
      chk("rst_card_req", card_req, 0);
      chk("rst_player_total", player_total, 0);
      chk("rst_dealer_total", dealer_total, 0);
      chk("rst_result", result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b1;
      step();
      chk_en = 1'b1;

      // test 1: reset while dealer's first card is requested
      do_start();
      give(5, 1'b1, 1'b0);
      cyc = 0;
      while (!card_req && cyc < 20) begin
         step();
         cyc++;
      end
      chk("t1_req_before_rst", card_req, 1);
      chk("t1_busy_before_rst", busy, 1);
      rst = 1'b0;
      #1;
      chk("t1_card_req", card_req, 0);
      chk("t1_player_total", player_total, 0);
      chk("t1_dealer_total", dealer_total, 0);
      chk("t1_result", result, 0);
      chk("t1_busy", busy, 0);
      chk("t1_done", done, 0);
      p_q.delete();
      d_q.delete();
      step();
      rst = 1'b1;
      step();

      // test 2: push at 17, start during the player turn is ignored
      do_start();
      deal4(10, 9, 7, 8);
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t2_busy_mid", busy, 1);
      pulse(1'b0, 1'b1);
      wait_done(cyc);
      check_end("t2", 17, 17, 3);

      // test 3: player blackjack settles without a player turn
      do_start();
      deal4(1, 10, 13, 6);
      wait_done(cyc);
      chk("t3_no_turn", (cyc <= 2), 1);
      check_end("t3", 21, 16, 1);

      // test 4: soft hand hardens then busts; dealer draws nothing
      do_start();
      deal4(1, 10, 5, 7);
      chk("t4_soft16_total", player_total, 16);
      chk("t4_soft16_flag", player_soft, 1);
      step();
      pulse(1'b1, 1'b0);
      give(10, 1'b1, 1'b0);
      chk("t4_hard16_total", player_total, 16);
      chk("t4_hard16_flag", player_soft, 0);
      pulse(1'b1, 1'b0);
      give(9, 1'b1, 1'b0);
      r0 = req_cnt;
      wait_done(cyc);
      chk("t4_no_dealer_req", req_cnt - r0, 0);
      check_end("t4", 25, 17, 2);

      // test 5: dealer stands on soft 17, rank 14 is discarded
      do_start();
      give(10, 1'b1, 1'b0);
      give(1, 1'b0, 1'b0);
      give(8, 1'b1, 1'b0);
      give(14, 1'b0, 1'b1);
      give(6, 1'b0, 1'b0);
      step();
      pulse(1'b0, 1'b1);
      wait_done(cyc);
      check_end("t5", 18, 17, 1);

      // test 6: hit+stand together is a stand; continuous valid, one card per request
      do_start();
      deal4(10, 2, 9, 2);
      step();
      chk_en = 1'b0;
      a0 = acc_cnt;
      card_rank    = 4'd2;
      card_valid   = 1'b1;
      player_hit   = 1'b1;
      player_stand = 1'b1;
      step();
      player_hit   = 1'b0;
      player_stand = 1'b0;
      while (best_of(d_q) < 17 && d_q.size() < 8) d_q.push_back(2);
      wait_done(cyc);
      card_valid = 1'b0;
      chk("t6_cards_taken", acc_cnt - a0, 6);
      chk("t6_cards_model", acc_cnt - a0, d_q.size() - 2);
      check_end("t6", 19, 16, 1);
      chk_en = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
